// File: rtl/ram_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_fifo_pkg
//  Description : Shared defaults and type definitions for the RAM-backed FIFO
//                controller (controller FSM states and arbiter grant encoding).
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package ram_fifo_pkg;

  localparam int DATA_W_DEF = 10;  // RAM word width
  localparam int ADDR_W_DEF = 8;   // RAM address width, depth = 2**ADDR_W

  // Controller state: S_RD is the single cycle in which Ram_Dout carries the
  // word whose read was issued on the previous cycle.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RD   = 1'b1
  } state_t;

  // Which side won the most recent push/pop conflict.
  typedef enum logic {
    GRANT_WRITE = 1'b0,
    GRANT_READ  = 1'b1
  } grant_t;

endpackage : ram_fifo_pkg
`default_nettype wire

// File: rtl/ram_fifo_arb.sv
`default_nettype none
// ============================================================================
//  Module      : ram_fifo_arb
//  Description : Two-way alternating-priority arbiter for the single RAM port.
//                A lone request always wins. When both sides request in the
//                same cycle, the side that lost the previous conflict wins and
//                the remembered winner is updated.
//  Ports       : clk       - clock
//                rst       - synchronous active-high reset
//                i_wr_req  - push side is eligible for the RAM port
//                i_rd_req  - pop side is eligible for the RAM port
//                o_wr_gnt  - push side owns the RAM port this cycle
//                o_rd_gnt  - pop side owns the RAM port this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module ram_fifo_arb
  import ram_fifo_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_wr_req,
  input  logic i_rd_req,
  output logic o_wr_gnt,
  output logic o_rd_gnt
);

  grant_t r_last_grant;
  logic   w_conflict;

  assign w_conflict = i_wr_req & i_rd_req;

  // Grants are mutually exclusive by construction: on a conflict exactly one
  // of the two terms below is true.
  always_comb begin
    o_rd_gnt = i_rd_req & (~i_wr_req | (r_last_grant == GRANT_WRITE));
    o_wr_gnt = i_wr_req & (~i_rd_req | (r_last_grant == GRANT_READ));
  end

  // Reset to GRANT_WRITE so the very first conflict goes to the read side.
  // Only conflicts move the priority; uncontested grants leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= GRANT_WRITE;
    end else if (w_conflict) begin
      r_last_grant <= (r_last_grant == GRANT_WRITE) ? GRANT_READ : GRANT_WRITE;
    end
  end

endmodule : ram_fifo_arb
`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ram_fifo_ctrl
//  Description : Circular-buffer controller turning a single-port synchronous
//                RAM (one-cycle read latency) into a FIFO with a push port and
//                a registered valid/ready pop port. Push and pop share the RAM
//                port through an alternating-priority arbiter.
//  Options     : RAM_FIFO_STATUS_EN - adds sticky Ovf_Err / Udf_Err outputs.
//  Ports       : Clk, Rst           - clock, synchronous active-high reset
//                In_Data/In_Valid   - push data / request
//                In_Ready           - push accepted this cycle (combinational)
//                Out_Data/Out_Valid - registered pop data / valid
//                Out_Ready          - consumer takes Out_Data
//                Count              - words in RAM not yet read-issued
//                Ram_Din/Addr/En/We - RAM controls (combinational from grant)
//                Ram_Dout           - RAM read data, valid one cycle after read
//                Ovf_Err/Udf_Err    - sticky status (RAM_FIFO_STATUS_EN only)
//  Revision    : 1.0  initial release
// ============================================================================
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] In_Data,
  input  logic              In_Valid,
  output logic              In_Ready,
  output logic [DATA_W-1:0] Out_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [ADDR_W:0]   Count,
  output logic [DATA_W-1:0] Ram_Din,
  output logic [ADDR_W-1:0] Ram_Addr,
  output logic              Ram_En,
  output logic              Ram_We,
  input  logic [DATA_W-1:0] Ram_Dout
`ifdef RAM_FIFO_STATUS_EN
  ,
  output logic              Ovf_Err,
  output logic              Udf_Err
`endif
);

  localparam logic [ADDR_W:0]   c_DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   c_CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] c_PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  state_t            r_state;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_wr_req;
  logic w_rd_req;
  logic w_wr_gnt;
  logic w_rd_gnt;

  assign w_full  = (r_count == c_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_pop   = r_out_valid & Out_Ready;

  // Requests are masked during reset so the RAM sees no access in that cycle.
  assign w_wr_req = ~Rst & In_Valid & ~w_full;

  // A read may only be issued when the output register is free by the time
  // the data comes back: either empty now or being popped this cycle. Being
  // in S_IDLE limits the pop side to one read per two cycles.
  assign w_rd_req = ~Rst & ~w_empty & (r_state == S_IDLE) & (~r_out_valid | Out_Ready);

  ram_fifo_arb u_arb (
    .clk      (Clk),
    .rst      (Rst),
    .i_wr_req (w_wr_req),
    .i_rd_req (w_rd_req),
    .o_wr_gnt (w_wr_gnt),
    .o_rd_gnt (w_rd_gnt)
  );

  // RAM port is driven straight from the grant; idle cycles park at zero.
  always_comb begin
    Ram_En   = w_wr_gnt | w_rd_gnt;
    Ram_We   = w_wr_gnt;
    Ram_Din  = '0;
    Ram_Addr = '0;
    if (w_wr_gnt) begin
      Ram_Addr = r_wr_ptr;
      Ram_Din  = In_Data;
    end else if (w_rd_gnt) begin
      Ram_Addr = r_rd_ptr;
    end
  end

  assign In_Ready  = w_wr_gnt;
  assign Count     = r_count;
  assign Out_Data  = r_out_data;
  assign Out_Valid = r_out_valid;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_state     <= S_IDLE;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_wr_gnt) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_rd_gnt) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end

      // Grants are exclusive, so Count moves by at most one per cycle.
      if (w_wr_gnt) begin
        r_count <= r_count + c_CNT_ONE;
      end else if (w_rd_gnt) begin
        r_count <= r_count - c_CNT_ONE;
      end

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_out_valid <= 1'b0;
          end
          if (w_rd_gnt) begin
            r_state <= S_RD;
          end
        end
        S_RD: begin
          // The output register is guaranteed free here (checked when the
          // read was issued), so the capture never overwrites unread data.
          r_out_data  <= Ram_Dout;
          r_out_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RAM_FIFO_STATUS_EN
  logic r_ovf_err;
  logic r_udf_err;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_ovf_err <= 1'b0;
      r_udf_err <= 1'b0;
    end else begin
      if (In_Valid && w_full) begin
        r_ovf_err <= 1'b1;
      end
      // Underflow: consumer is asking, nothing is held, nothing is stored
      // and no read is in flight.
      if (Out_Ready && !r_out_valid && w_empty && (r_state == S_IDLE)) begin
        r_udf_err <= 1'b1;
      end
    end
  end

  assign Ovf_Err = r_ovf_err;
  assign Udf_Err = r_udf_err;
`endif

endmodule : ram_fifo_ctrl
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_fifo_ctrl
//  Description : Self-checking bench for ram_fifo_ctrl with a behavioural RAM
//                and a transaction-level reference model (data queue plus
//                stored-word count, pointer indices and arbitration priority).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_fifo_ctrl;

  localparam int DW = 10;
  localparam int AW = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW:0]   count;
  logic [DW-1:0] ram_din;
  logic [AW-1:0] ram_addr;
  logic          ram_en;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  always #5 clk = ~clk;

  ram_fifo_ctrl dut (
    .Clk       (clk),
    .Rst       (rst),
    .In_Data   (in_data),
    .In_Valid  (in_valid),
    .In_Ready  (in_ready),
    .Out_Data  (out_data),
    .Out_Valid (out_valid),
    .Out_Ready (out_ready),
    .Count     (count),
    .Ram_Din   (ram_din),
    .Ram_Addr  (ram_addr),
    .Ram_En    (ram_en),
    .Ram_We    (ram_we),
    .Ram_Dout  (ram_dout)
  );

  // 256 x 10 single-port synchronous RAM, read data one cycle after the read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout      <= mem[ram_addr];
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int  m_q[$];        // accepted words, oldest first, not yet popped
  int  m_cnt;         // words stored and not yet read-issued
  int  m_wp, m_rp;    // next write / read slot index
  bit  m_ov;          // a word is presented on the pop port
  bit  m_rd_prev;     // a read was issued last cycle (data arrives now)
  bit  m_last_rd;     // last conflict was won by the read side
  bit  m_live = 0;    // model is meaningful only after the first reset
  bit  last_acc;      // push accepted in the most recent cycle

  task automatic cycle();
    bit wr_req, rd_req, e_wr, e_rd;
    @(negedge clk);
    wr_req = !rst && in_valid && (m_cnt < DEPTH);
    rd_req = !rst && (m_cnt > 0) && !m_rd_prev && (!m_ov || out_ready);
    if (wr_req && rd_req) begin
      e_rd = !m_last_rd;
      e_wr = m_last_rd;
    end else begin
      e_wr = wr_req;
      e_rd = rd_req;
    end
    if (m_live) begin
      chk("count", int'(count), m_cnt);
      chk("out_valid", int'(out_valid), int'(m_ov));
      if (m_ov && m_q.size() > 0) chk("out_data", int'(out_data), m_q[0]);
      chk("in_ready", int'(in_ready), int'(e_wr));
      chk("ram_en", int'(ram_en), int'(e_wr | e_rd));
      chk("ram_we", int'(ram_we), int'(e_wr));
      if (e_wr) begin
        chk("wr_addr", int'(ram_addr), m_wp);
        chk("wr_din", int'(ram_din), int'(in_data));
      end
      if (e_rd) chk("rd_addr", int'(ram_addr), m_rp);
    end
    last_acc = e_wr;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_cnt = 0; m_wp = 0; m_rp = 0;
      m_ov = 0; m_rd_prev = 0; m_last_rd = 0;
      m_live = 1;
    end else begin
      if (m_ov && out_ready && !m_rd_prev) void'(m_q.pop_front());
      if (e_wr) begin
        m_q.push_back(int'(in_data));
        m_wp = (m_wp + 1) % DEPTH;
        m_cnt++;
      end
      if (e_rd) begin
        m_rp = (m_rp + 1) % DEPTH;
        m_cnt--;
      end
      if (m_rd_prev)                 m_ov = 1;
      else if (m_ov && out_ready)    m_ov = 0;
      if (wr_req && rd_req) m_last_rd = e_rd;
      m_rd_prev = e_rd;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  // Hold a word on the push port until the model sees it accepted.
  task automatic push_word(input int val);
    int t;
    in_valid = 1'b1;
    in_data  = DW'(val);
    t = 0;
    do begin
      cycle();
      t++;
    end while (!last_acc && t < 20);
    if (!last_acc) chk("push_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (m_q.size() > 0 && t < budget) begin
      cycle();
      t++;
    end
    chk("drain_done", m_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    // ---- reset state ----
    do_reset();
    @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_ram_en", int'(ram_en), 0);
    in_valid = 1'b1;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // ---- two pushes, consumer stalled ----
    push_word(40);
    push_word(60);
    repeat (5) cycle();
    chk("hold_data", int'(out_data), 40);
    chk("hold_valid", int'(out_valid), 1);
    chk("hold_count", int'(count), 1);
    drain(20);

    // ---- fill to full, then drain with pointer wrap ----
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) push_word(i);
    chk("full_count", int'(count), DEPTH);
    in_valid = 1'b1; in_data = 10'd999;
    cycle();
    @(negedge clk);
    chk("full_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    drain(2000);

    // ---- continuous push with consumer always ready ----
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      cycle();
      chk("cnt_bound", int'(count <= 9'd256), 1);
    end
    drain(600);

    // ---- random traffic ----
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) == 0);
      in_data   = DW'($urandom);
      cycle();
    end
    drain(800);

    // ---- reset while a read is in flight with Count = 5 ----
    do_reset();
    begin
      int t;
      t = 0;
      while (!(m_cnt == 6 && m_ov && !m_rd_prev) && t < 50) begin
        in_valid = (m_cnt < 6);
        in_data  = DW'(100 + t);
        cycle();
        t++;
      end
      if (t >= 50) chk("setup_timeout", 0, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("srd_count", int'(count), 5);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_srd_count", int'(count), 0);
    chk("rst_srd_valid", int'(out_valid), 0);
    cycle();
    chk("no_capture_valid", int'(out_valid), 0);
    chk("no_capture_count", int'(count), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule : tb_ram_fifo_ctrl
`default_nettype wire
